// File: rtl/div_sequencer_if.sv
// div_sequencer_if
//   Request/response bundle between the pipeline and the iterative divider.
//   master : pipeline side, drives start/sign/a/b/flush, observes status and result
//   slave  : divider side
//   Signals:
//     start    request, sampled by the divider only when it is idle or done
//     sign     1 = signed divide, 0 = unsigned
//     a, b     dividend and divisor
//     flush    abort the operation in flight
//     busy     stall request to the pipeline
//     done     one-cycle completion pulse
//     div_zero divisor of the completed operation was zero
//     result   {remainder, quotient}
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               sign;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               flush;
  logic               busy;
  logic               done;
  logic               div_zero;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, sign, a, b, flush,
    input  busy, done, div_zero, result
  );

  modport slave (
    input  start, sign, a, b, flush,
    output busy, done, div_zero, result
  );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer
//   Multi-cycle restoring divider with its own sequencer, one quotient bit per
//   clock. Handles signed and unsigned operands; result is {remainder, quotient}.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous, active-high reset
//     bus  div_sequencer_if.slave (start/sign/a/b/flush in, busy/done/div_zero/result out)
//
//   state | meaning
//   IDLE  | waiting for start
//   PREP  | operands latched; form magnitudes, detect divide-by-zero
//   RUN   | one restoring step per clock, WIDTH steps
//   FIX   | apply signs to quotient and remainder
//   DONE  | done pulse; result register already holds the answer
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  div_sequencer_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   q_fix, r_fix;

  // Magnitudes; the most-negative value maps onto itself, which is correct
  // when read as unsigned.
  assign abs_a = (sign_q && a_q[WIDTH-1]) ? (~a_q + ONE) : a_q;
  assign abs_b = (sign_q && b_q[WIDTH-1]) ? (~b_q + ONE) : b_q;

  // Partial remainder shifted left with the next dividend bit; kept one bit
  // wider so the compare against the divisor never overflows.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  assign q_fix = neg_q_q ? (~quo_q + ONE) : quo_q;
  assign r_fix = neg_r_q ? (~rem_q + ONE) : rem_q;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_d     = sign_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sign_d  = bus.sign;
          state_d = PREP;
        end
      end

      PREP: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (b_q == '0) begin
          result_d   = {a_q, {WIDTH{1'b1}}};
          div_zero_d = 1'b1;
          state_d    = DONE;
        end else begin
          quo_d   = abs_a;
          dvs_d   = abs_b;
          rem_d   = '0;
          cnt_d   = '0;
          neg_q_d = sign_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r_d = sign_q & a_q[WIDTH-1];
          state_d = RUN;
        end
      end

      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          // diff[WIDTH] set means the subtraction borrowed: keep the shift.
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          result_d   = {r_fix, q_fix};
          div_zero_d = 1'b0;
          state_d    = DONE;
        end
      end

      DONE: begin
        if (bus.start && !bus.flush) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sign_d  = bus.sign;
          state_d = PREP;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q == PREP) || (state_q == RUN) || (state_q == FIX);
  assign bus.done     = (state_q == DONE);
  assign bus.div_zero = div_zero_q;
  assign bus.result   = result_q;

endmodule
